// File: rtl/fir_filter_seq_param.sv
// Time-multiplexed signed FIR: one shared MAC walks NTAPS taps per sample,
// valid/ready streams on both sides, shadow/active coefficient banks with deferred commit.
module fir_filter_seq_param #(
  parameter int NTAPS     = 8,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0,
  localparam int AW       = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              coef_commit,
  output logic              coef_pending,
  input  logic [AW-1:0]     coef_rd_addr,
  output logic [COEF_W-1:0] coef_rd_data,
  output logic              busy
);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((longint'(1) << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;

  logic signed [DATA_W-1:0] hist   [NTAPS];
  logic signed [COEF_W-1:0] shadow [NTAPS];
  logic signed [COEF_W-1:0] active [NTAPS];

  logic [AW-1:0]            wr_ptr, head, k, rd_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rounded, shifted;
  logic                     accept, last_tap, copy, sat_hi, sat_lo;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_ready && in_valid;
  assign last_tap = (k == AW'(NTAPS-1));
  // A commit seen in IDLE, or one parked while busy, copies at the end of an IDLE cycle.
  assign copy     = in_ready && (coef_commit || coef_pending);

  // x[n-k] lives at head-k modulo NTAPS; head is where the newest sample was written.
  assign rd_idx = (head >= k) ? head - k : head + AW'(NTAPS) - k;
  assign prod   = active[k] * hist[rd_idx];

  assign rounded = (ACC_W+1)'(acc) + RND;
  assign shifted = rounded >>> OUT_SHIFT;
  assign sat_hi  = shifted > MAXV;
  assign sat_lo  = shifted < MINV;

  assign coef_rd_data = (32'(coef_rd_addr) < NTAPS) ? active[coef_rd_addr] : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = MAC;
      MAC:     if (last_tap) state_nx = OUT;
      OUT:     if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      head         <= '0;
      k            <= '0;
      acc          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sat      <= 1'b0;
      coef_pending <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist[i]   <= '0;
        shadow[i] <= (i == 0) ? COEF_W'(1) : '0;
        active[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      state <= state_nx;

      if (coef_we && (32'(coef_addr) < NTAPS)) shadow[coef_addr] <= coef_wdata;
      if (copy) begin
        active       <= shadow;
        coef_pending <= 1'b0;
      end else if (coef_commit) begin
        coef_pending <= 1'b1;
      end

      if (accept) begin
        hist[wr_ptr] <= in_data;
        head         <= wr_ptr;
        wr_ptr       <= (wr_ptr == AW'(NTAPS-1)) ? '0 : wr_ptr + 1'b1;
        acc          <= '0;
        k            <= '0;
      end

      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + 1'b1;
      end

      // Result is registered on the first OUT cycle and then held until taken.
      if (state == OUT && !out_valid) begin
        out_valid <= 1'b1;
        out_sat   <= sat_hi || sat_lo;
        out_data  <= sat_hi ? OUT_W'(MAXV) : (sat_lo ? OUT_W'(MINV) : OUT_W'(shifted));
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
